// File: rtl/dmem_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank_ctrl
// Description : Load/store front end for NUM_BANKS byte-wide, byte-interleaved
//               data-memory banks. Accepts one request at a time through a
//               valid/ready handshake, spreads byte/half/word lanes over
//               adjacent banks, flags misaligned or illegal-size accesses,
//               waits RD_LAT cycles for bank read data and returns a
//               sign- or zero-extended result with a one-cycle response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank_ctrl #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_DW   = 8,
    parameter int ROW_W     = 10,
    parameter int RD_LAT    = 1,
    parameter int ADDR_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [1:0]                   req_size,
    input  logic                         req_unsigned,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         resp_valid,
    output logic [31:0]                  resp_rdata,
    output logic                         resp_err,
    output logic [NUM_BANKS-1:0]         ce_mem,
    output logic [NUM_BANKS-1:0]         we_mem,
    output logic [ROW_W-1:0]             bank_addr,
    output logic [NUM_BANKS*BANK_DW-1:0] bank_wdata,
    input  logic [NUM_BANKS*BANK_DW-1:0] bank_rdata
);

    localparam int c_BW    = $clog2(NUM_BANKS);
    localparam int c_DW    = NUM_BANKS * BANK_DW;
    localparam int c_CNT_W = 3;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    // State and captured request
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   r_we;
    logic                   r_unsigned;
    logic [1:0]             r_size;
    logic [c_BW-1:0]        r_offset;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;

    // Registered outputs and their next values
    logic [NUM_BANKS-1:0]   r_ce,         w_ce_nxt;
    logic [NUM_BANKS-1:0]   r_we_mem,     w_we_mem_nxt;
    logic [ROW_W-1:0]       r_bank_addr,  w_bank_addr_nxt;
    logic [c_DW-1:0]        r_bank_wdata, w_bank_wdata_nxt;
    logic                   r_resp_valid, w_resp_valid_nxt;
    logic                   r_resp_err,   w_resp_err_nxt;
    logic [31:0]            r_resp_rdata, w_resp_rdata_nxt;

    // Incoming request decode
    logic                   w_accept;
    logic [c_BW-1:0]        w_req_off;
    logic [ROW_W-1:0]       w_req_row;
    logic                   w_req_err;
    logic [NUM_BANKS-1:0]   w_lane_base;
    logic [NUM_BANKS-1:0]   w_req_mask;
    logic [c_DW-1:0]        w_wd_base;
    logic [c_DW-1:0]        w_req_wd;

    // Load result assembly
    logic [c_BW-1:0]        w_idx;
    logic [31:0]            w_ld_raw;
    logic                   w_sign;
    logic [31:0]            w_ld_data;

    // Address bits above the row field are intentionally ignored
    logic                   w_unused_addr;
    assign w_unused_addr = ^req_addr;

    assign req_ready  = (r_state == c_S_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_req_off  = req_addr[c_BW-1:0];
    assign w_req_row  = req_addr[c_BW +: ROW_W];

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign ce_mem     = r_ce;
    assign we_mem     = r_we_mem;
    assign bank_addr  = r_bank_addr;
    assign bank_wdata = r_bank_wdata;

    // Decode lane mask, lane-shifted store data and alignment error of the request
    always_comb begin
        w_lane_base = '0;
        w_wd_base   = '0;
        case (req_size)
            2'd0: begin
                w_lane_base[0]    = 1'b1;
                w_wd_base[7:0]    = req_wdata[7:0];
            end
            2'd1: begin
                w_lane_base[1:0]  = 2'b11;
                w_wd_base[15:0]   = req_wdata[15:0];
            end
            2'd2: begin
                w_lane_base[3:0]  = 4'b1111;
                w_wd_base[31:0]   = req_wdata;
            end
            default: begin
                w_lane_base = '0;
                w_wd_base   = '0;
            end
        endcase
        w_req_mask = w_lane_base << w_req_off;
        w_req_wd   = w_wd_base << {w_req_off, 3'b000};
        w_req_err  = (req_size == 2'd3) ||
                     ((req_size == 2'd1) && w_req_off[0]) ||
                     ((req_size == 2'd2) && (w_req_off[1:0] != 2'b00));
    end

    // Gather bytes from banks offset..offset+3 and extend to 32 bits
    always_comb begin
        w_ld_raw = '0;
        w_idx    = '0;
        for (int j = 0; j < 4; j++) begin
            w_idx = r_offset + c_BW'(j);
            w_ld_raw[8*j +: 8] = bank_rdata[{w_idx, 3'b000} +: 8];
        end
        case (r_size)
            2'd0:    w_sign = w_ld_raw[7];
            2'd1:    w_sign = w_ld_raw[15];
            default: w_sign = 1'b0;
        endcase
        if (r_unsigned) begin
            w_sign = 1'b0;
        end
        case (r_size)
            2'd0:    w_ld_data = {{24{w_sign}}, w_ld_raw[7:0]};
            2'd1:    w_ld_data = {{16{w_sign}}, w_ld_raw[15:0]};
            default: w_ld_data = w_ld_raw;
        endcase
    end

    // Next-state and next-output decode; outputs are precomputed so they register with the state
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ce_nxt         = '0;
        w_we_mem_nxt     = '0;
        w_bank_addr_nxt  = r_bank_addr;
        w_bank_wdata_nxt = '0;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = '0;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_nxt      = c_S_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt      = c_S_ISSUE;
                        w_ce_nxt         = w_req_mask;
                        w_we_mem_nxt     = req_we ? w_req_mask : '0;
                        w_bank_addr_nxt  = w_req_row;
                        w_bank_wdata_nxt = req_we ? w_req_wd : '0;
                    end
                end
            end
            c_S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt      = c_S_RESP;
                    w_resp_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = c_S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            c_S_WAIT: begin
                if (r_cnt == c_CNT_W'(RD_LAT - 1)) begin
                    w_state_nxt      = c_S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = w_ld_data;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_S_RESP: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State, latency counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_cnt        <= '0;
            r_ce         <= '0;
            r_we_mem     <= '0;
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ce         <= w_ce_nxt;
            r_we_mem     <= w_we_mem_nxt;
            r_bank_addr  <= w_bank_addr_nxt;
            r_bank_wdata <= w_bank_wdata_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
        end
    end

    // Capture the request attributes needed after the accept cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'd0;
            r_offset   <= '0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_offset   <= w_req_off;
        end
    end

endmodule
`default_nettype wire
